a2d_sequencer: RTL and testbench

- Sequences the on-board ADC128S 12-bit A2D converter over SPI.
- Round-robins the four used channels on a periodic tick: BATT=ch0, CURR=ch1, BRAKE=ch3, TORQUE=ch4.
- Holds the latest 12-bit result for each channel in a register for the eBike control logic.
- Contains its own SPI master (mode 3, 16-bit frames) and the two-frame conversion protocol. In that protocol, frame 1 carries the channel command and frame 2 returns that channel's data.

---
 rtl/a2d_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_a2d_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin ADC128S sequencer with built-in mode-3 SPI master (16-bit frames).
// Optional result smoothing (3*old+new)/4 when A2D_FILTER_EN is defined.
module a2d_sequencer #(
  parameter int unsigned CONV_PERIOD = 4096,
  parameter int unsigned GAP_CLKS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt,
  output logic [2:0]  chnl
);

  localparam int unsigned CNT_W = $clog2(CONV_PERIOD);
  localparam int unsigned GAP_W = $clog2(GAP_CLKS + 1);

  localparam logic [4:0] DIV_START  = 5'b10111;
  localparam logic [4:0] DIV_SAMPLE = 5'b01111;
  localparam logic [4:0] DIV_SHIFT  = 5'b11111;
  localparam logic [4:0] DIV_LAST   = 5'b11110;
  localparam logic [4:0] BITS       = 5'd16;

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [4:0]         div_q, div_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]        shift_q, shift_d;
  logic               miso_q, miso_d;
  logic               ss_n_q, ss_n_d;
  logic [2:0]         chnl_q, chnl_d;
  logic               cnv_cmplt_q, cnv_cmplt_d;
  logic [11:0]        batt_q, batt_d, curr_q, curr_d, brake_q, brake_d, torque_q, torque_d;

  logic               tick_c, frame_run_c, frame_end_c;
  logic [11:0]        sample_c;
  logic [11:0]        batt_new_c, curr_new_c, brake_new_c, torque_new_c;

  assign tick_c      = (tick_cnt_q == CNT_W'(CONV_PERIOD - 1));
  assign frame_run_c = (state_q == CMD) || (state_q == READ);
  // Back porch: after the last shift the divider runs on until SCLK has been high long enough
  assign frame_end_c = frame_run_c && (bit_cnt_q == BITS) && (div_q == DIV_LAST);
  assign sample_c    = shift_q[11:0];

`ifdef A2D_FILTER_EN
  logic [3:0] seeded_q, seeded_d;

  function automatic logic [11:0] smooth(input logic [11:0] old_v, input logic [11:0] new_v,
                                         input logic seeded);
    logic [13:0] acc;
    acc = 14'(3) * {2'b00, old_v} + {2'b00, new_v};
    return seeded ? 12'(acc >> 2) : new_v;
  endfunction

  assign batt_new_c   = smooth(batt_q,   sample_c, seeded_q[0]);
  assign curr_new_c   = smooth(curr_q,   sample_c, seeded_q[1]);
  assign brake_new_c  = smooth(brake_q,  sample_c, seeded_q[2]);
  assign torque_new_c = smooth(torque_q, sample_c, seeded_q[3]);
`else
  assign batt_new_c   = sample_c;
  assign curr_new_c   = sample_c;
  assign brake_new_c  = sample_c;
  assign torque_new_c = sample_c;
`endif

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
    gap_cnt_d   = gap_cnt_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    miso_d      = miso_q;
    ss_n_d      = ss_n_q;
    chnl_d      = chnl_q;
    cnv_cmplt_d = 1'b0;
    batt_d      = batt_q;
    curr_d      = curr_q;
    brake_d     = brake_q;
    torque_d    = torque_q;
`ifdef A2D_FILTER_EN
    seeded_d    = seeded_q;
`endif

    // SPI engine: sample MISO the clk before SCLK rises, shift on SCLK fall
    if (frame_run_c) begin
      div_d = frame_end_c ? div_q : div_q + 5'd1;
      if (div_q == DIV_SAMPLE) miso_d = MISO;
      if ((div_q == DIV_SHIFT) && (bit_cnt_q != BITS)) begin
        shift_d   = {shift_q[14:0], miso_q};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (tick_c) begin
          state_d   = CMD;
          ss_n_d    = 1'b0;
          div_d     = DIV_START;
          bit_cnt_d = '0;
          shift_d   = {2'b00, chnl_q, 11'h000};
        end
      end
      CMD: begin
        if (frame_end_c) begin
          state_d   = GAP;
          ss_n_d    = 1'b1;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CLKS - 1)) begin
          state_d   = READ;
          ss_n_d    = 1'b0;
          div_d     = DIV_START;
          bit_cnt_d = '0;
          shift_d   = 16'h0000;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      READ: begin
        if (frame_end_c) begin
          state_d = DONE;
          ss_n_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        // Write the selected result and step the pointer 0->1->3->4->0
        case (chnl_q)
          3'd0: begin
            batt_d      = batt_new_c;
            cnv_cmplt_d = 1'b1;
            chnl_d      = 3'd1;
`ifdef A2D_FILTER_EN
            seeded_d[0] = 1'b1;
`endif
          end
          3'd1: begin
            curr_d      = curr_new_c;
            cnv_cmplt_d = 1'b1;
            chnl_d      = 3'd3;
`ifdef A2D_FILTER_EN
            seeded_d[1] = 1'b1;
`endif
          end
          3'd3: begin
            brake_d     = brake_new_c;
            cnv_cmplt_d = 1'b1;
            chnl_d      = 3'd4;
`ifdef A2D_FILTER_EN
            seeded_d[2] = 1'b1;
`endif
          end
          3'd4: begin
            torque_d    = torque_new_c;
            cnv_cmplt_d = 1'b1;
            chnl_d      = 3'd0;
`ifdef A2D_FILTER_EN
            seeded_d[3] = 1'b1;
`endif
          end
          default: chnl_d = 3'd0;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      div_q       <= DIV_START;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      miso_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      chnl_q      <= 3'd0;
      cnv_cmplt_q <= 1'b0;
      batt_q      <= '0;
      curr_q      <= '0;
      brake_q     <= '0;
      torque_q    <= '0;
`ifdef A2D_FILTER_EN
      seeded_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      miso_q      <= miso_d;
      ss_n_q      <= ss_n_d;
      chnl_q      <= chnl_d;
      cnv_cmplt_q <= cnv_cmplt_d;
      batt_q      <= batt_d;
      curr_q      <= curr_d;
      brake_q     <= brake_d;
      torque_q    <= torque_d;
`ifdef A2D_FILTER_EN
      seeded_q    <= seeded_d;
`endif
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = div_q[4];
  assign MOSI      = shift_q[15];
  assign batt      = batt_q;
  assign curr      = curr_q;
  assign brake     = brake_q;
  assign torque    = torque_q;
  assign cnv_cmplt = cnv_cmplt_q;
  assign chnl      = chnl_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer: directed bench with an ADC128S-style slave model and SPI frame monitor.
module tb_a2d_sequencer;

  localparam int unsigned PERIOD = 1200;
  localparam int unsigned GAPC   = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, cnv_cmplt;
  logic [11:0] batt, curr, brake, torque;
  logic [2:0]  chnl;

  int checks = 0;
  int errors = 0;

  a2d_sequencer #(.CONV_PERIOD(PERIOD), .GAP_CLKS(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque),
    .cnv_cmplt(cnv_cmplt), .chnl(chnl)
  );

  always #5 clk = ~clk;

  // Slave model: shows tx[15] at SS_n fall, shifts on each SCLK fall, captures MOSI on SCLK rise
  logic [11:0] ana [0:7];
  logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_cmplt = 1'b0, since_ok = 1'b0;
  logic [15:0] tx = '0, cap = '0;
  logic [2:0]  next_chan = 3'd0;
  int          cap_idx = 0, low_len = 0, high_len = 0, fall_cnt = 0, since_fall = 0;
  int          frames_started = 0, period_err = 0, cmplt_cnt = 0, wide_err = 0;
  logic [15:0] cmd_hist [$];
  int          low_hist [$];
  int          fall_hist [$];
  int          gap_hist [$];
  logic [2:0]  chnl_hist [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss = 1'b1; prev_sclk = 1'b1; since_ok = 1'b0;
      next_chan = 3'd0; high_len = 0; low_len = 0; MISO = 1'b0;
    end else begin
      if (prev_ss && !SS_n) begin
        gap_hist.push_back(high_len);
        frames_started++;
        low_len = 0; fall_cnt = 0; since_ok = 1'b0;
        cap = '0; cap[15] = MOSI; cap_idx = 14;
        tx = {4'h0, ana[next_chan]};
        MISO = tx[15];
      end
      if (!SS_n) begin
        low_len++;
        if (prev_sclk && !SCLK) begin
          fall_cnt++;
          if (since_ok && since_fall != 32) period_err++;
          since_fall = 0; since_ok = 1'b1;
          tx = tx << 1;
          MISO = tx[15];
        end
        if (!prev_sclk && SCLK && cap_idx >= 0) begin
          cap[cap_idx] = MOSI;
          cap_idx--;
        end
        since_fall++;
      end
      if (!prev_ss && SS_n) begin
        cmd_hist.push_back(cap);
        low_hist.push_back(low_len);
        fall_hist.push_back(fall_cnt);
        next_chan = cap[13:11];
        high_len = 0;
      end
      if (SS_n) high_len++;
      prev_ss = SS_n;
      prev_sclk = SCLK;
    end
    if (cnv_cmplt) begin
      cmplt_cnt++;
      chnl_hist.push_back(chnl);
      if (prev_cmplt) wide_err++;
    end
    prev_cmplt = cnv_cmplt;
  end

  task automatic test_reset;
    int early;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (SS_n !== 1'b1 || SCLK !== 1'b1 || MOSI !== 1'b0) begin
      errors++; $display("FAIL reset_spi: SS_n/SCLK/MOSI=%b%b%b expected 110", SS_n, SCLK, MOSI);
    end
    checks++;
    if ({batt, curr, brake, torque} !== 48'h0) begin
      errors++; $display("FAIL reset_results: got %h expected 0", {batt, curr, brake, torque});
    end
    checks++;
    if (cnv_cmplt !== 1'b0 || chnl !== 3'd0) begin
      errors++; $display("FAIL reset_status: cnv_cmplt=%b chnl=%0d expected 0 0", cnv_cmplt, chnl);
    end
    rst_n = 1'b1;
    early = 0;
    repeat (PERIOD - 1) begin
      @(negedge clk);
      if (SS_n !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL reset_early_start: %0d low cycles before tick expected 0", early);
    end
    @(negedge clk);
    checks++;
    if (SS_n !== 1'b0) begin
      errors++; $display("FAIL first_tick_start: SS_n=%b expected 0", SS_n);
    end
  endtask

  task automatic test_conversions;
    logic [2:0]  exp_next [0:4];
    logic [15:0] exp_cmd [0:4];
    int base, n;
    exp_next[0] = 3'd1; exp_next[1] = 3'd3; exp_next[2] = 3'd4; exp_next[3] = 3'd0; exp_next[4] = 3'd1;
    exp_cmd[0] = 16'h0000; exp_cmd[1] = 16'h0800; exp_cmd[2] = 16'h1800;
    exp_cmd[3] = 16'h2000; exp_cmd[4] = 16'h0000;
    base = cmplt_cnt;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (cmplt_cnt < base + k + 1 && n < 1500) begin @(negedge clk); n++; end
      checks++;
      if (cmplt_cnt != base + k + 1) begin
        errors++; $display("FAIL conv_timeout_%0d: pulses=%0d expected %0d", k, cmplt_cnt - base, k + 1);
      end
      checks++;
      if (chnl !== exp_next[k]) begin
        errors++; $display("FAIL chnl_after_%0d: got %0d expected %0d", k, chnl, exp_next[k]);
      end
      if (k == 0) begin
        checks++;
        if (batt !== 12'hABC || {curr, brake, torque} !== 36'h0) begin
          errors++; $display("FAIL first_route: got %h %h %h %h expected abc 000 000 000",
                             batt, curr, brake, torque);
        end
      end
    end
    checks++;
    if (batt !== 12'hABC || curr !== 12'h123 || brake !== 12'h456 || torque !== 12'h789) begin
      errors++; $display("FAIL result_route: got %h %h %h %h expected abc 123 456 789",
                         batt, curr, brake, torque);
    end
    checks++;
    if (cmd_hist.size() < 10) begin
      errors++; $display("FAIL frame_count: got %0d expected 10", cmd_hist.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (cmd_hist[2*k] !== exp_cmd[k] || cmd_hist[2*k+1] !== 16'h0000) begin
          errors++; $display("FAIL cmd_frame_%0d: got %h/%h expected %h/0000",
                             k, cmd_hist[2*k], cmd_hist[2*k+1], exp_cmd[k]);
        end
      end
    end
    checks++;
    if (wide_err != 0 || chnl_hist.size() != 5) begin
      errors++; $display("FAIL cmplt_pulses: wide=%0d count=%0d expected 0 5", wide_err, chnl_hist.size());
    end
  endtask

  task automatic test_frame_timing;
    int bad_low, bad_fall, bad_gap;
    bad_low = 0; bad_fall = 0; bad_gap = 0;
    foreach (low_hist[i]) if (low_hist[i] != 520) bad_low++;
    foreach (fall_hist[i]) if (fall_hist[i] != 16) bad_fall++;
    for (int i = 1; i < gap_hist.size(); i += 2) if (gap_hist[i] != int'(GAPC)) bad_gap++;
    checks++;
    if (bad_low != 0 || low_hist.size() == 0) begin
      errors++; $display("FAIL ss_low_len: %0d of %0d frames not 520 clk", bad_low, low_hist.size());
    end
    checks++;
    if (bad_fall != 0) begin
      errors++; $display("FAIL sclk_falls: %0d frames without 16 falls", bad_fall);
    end
    checks++;
    if (bad_gap != 0 || gap_hist.size() < 2) begin
      errors++; $display("FAIL ss_gap: %0d gaps not %0d clk", bad_gap, GAPC);
    end
    checks++;
    if (period_err != 0) begin
      errors++; $display("FAIL sclk_period: %0d periods not 32 clk", period_err);
    end
  endtask

  task automatic test_mid_frame_reset;
    int target, n, stale, base_c, base_f;
    target = frames_started + 2 - (frames_started % 2);
    n = 0;
    while (frames_started < target && n < 2500) begin @(negedge clk); n++; end
    checks++;
    if (frames_started < target) begin
      errors++; $display("FAIL read_frame_timeout: frames=%0d expected %0d", frames_started, target);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (SS_n !== 1'b0) begin
      errors++; $display("FAIL mid_frame_active: SS_n=%b expected 0", SS_n);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (SS_n !== 1'b1 || SCLK !== 1'b1 || cnv_cmplt !== 1'b0 || chnl !== 3'd0 || batt !== 12'h000) begin
      errors++; $display("FAIL async_abort: SS_n=%b SCLK=%b cmplt=%b chnl=%0d batt=%h expected 1 1 0 0 000",
                         SS_n, SCLK, cnv_cmplt, chnl, batt);
    end
    ana[0] = 12'h400;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base_c = cmplt_cnt;
    base_f = cmd_hist.size();
    stale = 0;
    repeat (PERIOD - 1) begin
      @(negedge clk);
      if (cnv_cmplt !== 1'b0 || SS_n !== 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL stale_activity: %0d cycles expected 0", stale);
    end
    n = 0;
    while (cmplt_cnt < base_c + 1 && n < 1500) begin @(negedge clk); n++; end
    checks++;
    if (cmplt_cnt != base_c + 1) begin
      errors++; $display("FAIL post_reset_timeout: pulses=%0d expected 1", cmplt_cnt - base_c);
    end
    checks++;
    if (batt !== 12'h400 || chnl !== 3'd1 || cmd_hist.size() <= base_f || cmd_hist[base_f] !== 16'h0000) begin
      errors++; $display("FAIL post_reset_ch0: batt=%h chnl=%0d expected 400 1", batt, chnl);
    end
  endtask

  task automatic test_filter;
    int base, n;
    logic [11:0] exp_batt;
`ifdef A2D_FILTER_EN
    exp_batt = 12'h500;
`else
    exp_batt = 12'h800;
`endif
    ana[0] = 12'h800;
    base = cmplt_cnt;
    n = 0;
    while (cmplt_cnt < base + 4 && n < 5200) begin @(negedge clk); n++; end
    checks++;
    if (cmplt_cnt != base + 4) begin
      errors++; $display("FAIL filter_timeout: pulses=%0d expected 4", cmplt_cnt - base);
    end
    checks++;
    if (batt !== exp_batt) begin
      errors++; $display("FAIL batt_update: got %h expected %h", batt, exp_batt);
    end
    checks++;
    if (curr !== 12'h123 || brake !== 12'h456 || torque !== 12'h789 || chnl !== 3'd1) begin
      errors++; $display("FAIL first_after_reset: got %h %h %h chnl=%0d expected 123 456 789 1",
                         curr, brake, torque, chnl);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ana[i] = 12'h000;
    ana[0] = 12'hABC; ana[1] = 12'h123; ana[3] = 12'h456; ana[4] = 12'h789;
    test_reset;
    test_conversions;
    test_frame_timing;
    test_mid_frame_reset;
    test_filter;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
